// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm controller: FSM state encoding,
// counter sizing and the default keypad codes.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED   = 3'd0,
        ST_EXIT_WAIT  = 3'd1,
        ST_ARMED      = 3'd2,
        ST_ENTRY_WAIT = 3'd3,
        ST_ALARM      = 3'd4
    } alarm_state_e;

    localparam logic [4:0] DEF_ARM_CODE    = 5'b10000;
    localparam logic [4:0] DEF_DISARM_CODE = 5'b00100;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/alarm_delay_timer.sv
// Loadable down-counter: after a load of V it stays running for V+1 cycles,
// pulsing expire_o in the last one, then idles at zero.
module alarm_delay_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         running_o,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = load_val_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) run_d = 1'b0;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign running_o = run_q;
    assign expire_o  = run_q && (cnt_q == '0);

endmodule

// File: rtl/alarm_controller.sv
// Arm / exit-delay / armed / entry-delay / alarm controller with wrong-code
// lockout and per-zone trigger latching. All outputs come straight from flops.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int                N_SENSORS      = 2,
    parameter int                CODE_W         = 5,
    parameter logic [CODE_W-1:0] ARM_CODE       = CODE_W'(DEF_ARM_CODE),
    parameter logic [CODE_W-1:0] DISARM_CODE    = CODE_W'(DEF_DISARM_CODE),
    parameter int                EXIT_DELAY     = 16,
    parameter int                ENTRY_DELAY    = 16,
    parameter int                MAX_FAILS      = 3,
    parameter int                LOCKOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic [CODE_W-1:0]    code,
    input  logic                 code_valid,
    output logic                 active,
    output logic                 alarm,
    output logic                 pending,
    output logic                 locked,
    output logic [N_SENSORS-1:0] zones,
    output logic [2:0]           state
);

    localparam int DLY_MAX = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int TW      = cnt_w(DLY_MAX);
    localparam int LW      = cnt_w(LOCKOUT_CYCLES);
    localparam int FW      = cnt_w(MAX_FAILS);

    alarm_state_e         state_q, state_d;
    logic [N_SENSORS-1:0] zones_q, zones_d;
    logic [FW-1:0]        fails_q, fails_d;
    logic                 active_q, alarm_q, pending_q;

    logic          fsm_load, fsm_run, fsm_exp;
    logic [TW-1:0] fsm_load_val;
    logic          lk_load, lk_run, lk_exp;
    logic          code_ok, is_arm, is_dis, good, bad;
    logic          tmr_unused;

    alarm_delay_timer #(.W(TW)) u_fsm_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (fsm_load),
        .load_val_i(fsm_load_val),
        .running_o (fsm_run),
        .expire_o  (fsm_exp)
    );

    alarm_delay_timer #(.W(LW)) u_lock_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (lk_load),
        .load_val_i(LW'(LOCKOUT_CYCLES - 1)),
        .running_o (lk_run),
        .expire_o  (lk_exp)
    );

    assign tmr_unused = ^{fsm_run, lk_exp};

    always_comb begin
        state_d      = state_q;
        zones_d      = zones_q;
        fails_d      = fails_q;
        fsm_load     = 1'b0;
        fsm_load_val = '0;
        lk_load      = 1'b0;
        good         = 1'b0;
        bad          = 1'b0;
        code_ok      = code_valid && !lk_run;
        is_arm       = code_ok && (code == ARM_CODE);
        is_dis       = code_ok && (code == DISARM_CODE);

        case (state_q)
            ST_DISARMED: begin
                if (is_arm) begin
                    state_d      = ST_EXIT_WAIT;
                    fsm_load     = 1'b1;
                    fsm_load_val = TW'(EXIT_DELAY - 1);
                    zones_d      = '0;
                    good         = 1'b1;
                end else begin
                    bad = code_ok;
                end
            end
            ST_EXIT_WAIT: begin
                if (is_dis) begin
                    state_d = ST_DISARMED;
                    good    = 1'b1;
                end else begin
                    bad = code_ok && !is_arm;
                    if (fsm_exp) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (is_dis) begin
                    state_d = ST_DISARMED;
                    good    = 1'b1;
                end else begin
                    bad = code_ok && !is_arm;
                    if (|sensor) begin
                        state_d      = ST_ENTRY_WAIT;
                        fsm_load     = 1'b1;
                        fsm_load_val = TW'(ENTRY_DELAY - 1);
                        zones_d      = sensor;
                    end
                end
            end
            ST_ENTRY_WAIT: begin
                zones_d = zones_q | sensor;
                if (is_dis) begin
                    state_d = ST_DISARMED;
                    good    = 1'b1;
                end else begin
                    bad = code_ok && !is_arm;
                    if (fsm_exp) state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (is_dis) begin
                    state_d = ST_DISARMED;
                    good    = 1'b1;
                end else begin
                    bad = code_ok && !is_arm;
                end
            end
            default: state_d = ST_DISARMED;
        endcase

        // Lockout entered while counting down the entry delay is treated as tamper.
        if (good) begin
            fails_d = '0;
        end else if (bad) begin
            if (fails_q == FW'(MAX_FAILS - 1)) begin
                fails_d = '0;
                lk_load = 1'b1;
                if (state_q == ST_ENTRY_WAIT) state_d = ST_ALARM;
            end else begin
                fails_d = fails_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_DISARMED;
            zones_q   <= '0;
            fails_q   <= '0;
            active_q  <= 1'b0;
            alarm_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            zones_q   <= zones_d;
            fails_q   <= fails_d;
            active_q  <= (state_d != ST_DISARMED);
            alarm_q   <= (state_d == ST_ALARM);
            pending_q <= (state_d == ST_EXIT_WAIT) || (state_d == ST_ENTRY_WAIT);
        end
    end

    assign active  = active_q;
    assign alarm   = alarm_q;
    assign pending = pending_q;
    assign locked  = lk_run;
    assign zones   = zones_q;
    assign state   = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a cycle-count model.
module tb_alarm_controller;
    import alarm_pkg::*;

    localparam int         NS = 2;
    localparam logic [4:0] C_ARM = 5'b10000;
    localparam logic [4:0] C_DIS = 5'b00100;
    localparam logic [4:0] C_BAD = 5'b00111;
    localparam int EXIT_D = 16, ENTRY_D = 16, MAXF = 3, LOCK_N = 64;
    localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] sensor = '0;
    logic [4:0]    code = '0;
    logic          code_valid = 1'b0;
    logic          active, alarm, pending, locked;
    logic [NS-1:0] zones;
    logic [2:0]    state;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alarm_controller dut (
        .clk(clk), .rst_n(rst_n), .sensor(sensor), .code(code), .code_valid(code_valid),
        .active(active), .alarm(alarm), .pending(pending), .locked(locked),
        .zones(zones), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: mode plus "cycles left" in the current delay and in the lockout.
    int            m_mode = M_DIS, m_left = 0, m_lock = 0, m_fails = 0;
    logic [NS-1:0] m_zones = '0;

    always @(posedge clk) begin : model
        bit ok, arm, dis, good, bad, lk;
        int nm;
        if (!rst_n) begin
            m_mode = M_DIS; m_left = 0; m_lock = 0; m_fails = 0; m_zones = '0;
        end else begin
            ok   = code_valid && (m_lock == 0);
            arm  = ok && (code == C_ARM);
            dis  = ok && (code == C_DIS);
            if (m_lock > 0) m_lock--;
            good = (m_mode == M_DIS) ? arm : dis;
            bad  = (m_mode == M_DIS) ? (ok && !arm) : (ok && !arm && !dis);
            lk   = 1'b0;
            if (good) m_fails = 0;
            else if (bad) begin
                m_fails++;
                if (m_fails == MAXF) begin
                    m_fails = 0; m_lock = LOCK_N; lk = 1'b1;
                end
            end
            nm = m_mode;
            case (m_mode)
                M_DIS:   if (arm) begin nm = M_EXIT; m_left = EXIT_D; m_zones = '0; end
                M_EXIT:  if (dis) nm = M_DIS; else if (m_left == 1) nm = M_ARMED; else m_left--;
                M_ARMED: if (dis) nm = M_DIS;
                         else if (|sensor) begin nm = M_ENTRY; m_left = ENTRY_D; m_zones = sensor; end
                M_ENTRY: begin
                    m_zones = m_zones | sensor;
                    if (dis) nm = M_DIS;
                    else if (lk || m_left == 1) nm = M_ALARM;
                    else m_left--;
                end
                default: if (dis) nm = M_DIS;
            endcase
            m_mode = nm;
        end
    end

    function automatic logic [2:0] st_of(input int m);
        case (m)
            M_EXIT:  return ST_EXIT_WAIT;
            M_ARMED: return ST_ARMED;
            M_ENTRY: return ST_ENTRY_WAIT;
            M_ALARM: return ST_ALARM;
            default: return ST_DISARMED;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_state",   32'(state),   32'(st_of(m_mode)));
            chk("m_active",  32'(active),  32'(m_mode != M_DIS));
            chk("m_alarm",   32'(alarm),   32'(m_mode == M_ALARM));
            chk("m_pending", 32'(pending), 32'(m_mode == M_EXIT || m_mode == M_ENTRY));
            chk("m_locked",  32'(locked),  32'(m_lock > 0));
            chk("m_zones",   32'(zones),   32'(m_zones));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [4:0] c);
        code = c; code_valid = 1'b1;
        tick();
        code_valid = 1'b0; code = '0;
    endtask

    task automatic arm_and_wait();
        strobe(C_ARM);
        repeat (EXIT_D) tick();
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_state", 32'(state), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_zones", 32'(zones), 0);
        chk("rst_locked", 32'(locked), 0);

        // Arm then wait out the exit delay
        strobe(C_ARM);
        chk("arm_active", 32'(active), 1);
        chk("arm_pending", 32'(pending), 1);
        repeat (EXIT_D - 1) tick();
        chk("exit_last_pending", 32'(pending), 1);
        tick();
        chk("armed_pending", 32'(pending), 0);
        chk("armed_state", 32'(state), 2);
        chk("armed_alarm", 32'(alarm), 0);

        // Intrusion then disarm inside the entry delay
        sensor = 2'b10; tick(); sensor = '0;
        chk("entry_state", 32'(state), 3);
        chk("entry_zones", 32'(zones), 2'b10);
        repeat (9) tick();
        strobe(C_DIS);
        chk("dis_state", 32'(state), 0);
        chk("dis_active", 32'(active), 0);
        chk("dis_alarm", 32'(alarm), 0);

        // Entry delay expiry raises the alarm exactly ENTRY_D cycles later
        arm_and_wait();
        chk("rearm_state", 32'(state), 2);
        sensor = 2'b01; tick(); sensor = '0;
        repeat (ENTRY_D - 1) tick();
        chk("entry_last_alarm", 32'(alarm), 0);
        tick();
        chk("expire_alarm", 32'(alarm), 1);
        chk("expire_zones", 32'(zones), 2'b01);
        strobe(C_DIS);
        chk("silence_alarm", 32'(alarm), 0);
        chk("silence_active", 32'(active), 0);

        // Lockout after three wrong codes; strobes ignored while locked
        strobe(C_BAD); strobe(C_BAD);
        chk("two_bad_locked", 32'(locked), 0);
        strobe(C_BAD);
        chk("lock_on", 32'(locked), 1);
        strobe(C_ARM);
        chk("lock_ignore_arm", 32'(state), 0);
        repeat (LOCK_N - 2) tick();
        chk("lock_last", 32'(locked), 1);
        tick();
        chk("lock_off", 32'(locked), 0);
        strobe(C_ARM);
        chk("post_lock_arm", 32'(active), 1);
        strobe(C_DIS);

        // Priority: disarm beats a sensor in the same ARMED cycle
        arm_and_wait();
        sensor = 2'b11; strobe(C_DIS); sensor = '0;
        chk("prio_state", 32'(state), 0);
        chk("prio_zones", 32'(zones), 0);

        // Tamper: lockout entered in ENTRY_WAIT forces the alarm
        arm_and_wait();
        sensor = 2'b10; tick(); sensor = '0;
        strobe(C_BAD); strobe(C_BAD);
        chk("tamper_pre", 32'(alarm), 0);
        strobe(C_BAD);
        chk("tamper_alarm", 32'(alarm), 1);
        chk("tamper_locked", 32'(locked), 1);

        // Reset during alarm with lockout active
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_outs", 32'({active, alarm, pending, locked}), 0);
        chk("mid_rst_zones", 32'(zones), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            rst_n = ($urandom_range(0, 799) != 0);
            sensor = ($urandom_range(0, 14) == 0) ? NS'($urandom_range(1, 3)) : '0;
            code_valid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            code = (r < 4) ? C_DIS : (r < 7) ? C_ARM : 5'($urandom);
            tick();
        end
        rst_n = 1'b1; code_valid = 1'b0; sensor = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Parametrised, clocked alarm controller: the sequential successor to the combinational two-sensor alarm mux. Monitors `N_SENSORS` motion inputs, accepts `CODE_W`-bit keypad codes as single-cycle strobes, and runs an arm/exit-delay/armed/entry-delay/alarm state machine. Adds wrong-code counting with timed lockout and per-zone trigger latching. Sits between the sensor/keypad input synchronisers and the siren/status-LED drivers.

## Interface
- `N_SENSORS`, 2, number of motion-sensor channels (1..16).
- `CODE_W`, 5, keypad code width.
- `ARM_CODE`, 5'b10000, code that arms; must differ from `DISARM_CODE`.
- `DISARM_CODE`, 5'b00100, code that disarms or silences.
- `EXIT_DELAY`, 16, cycles spent in EXIT_WAIT (≥1).
- `ENTRY_DELAY`, 16, cycles spent in ENTRY_WAIT (≥1).
- `MAX_FAILS`, 3, consecutive wrong codes that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 64, lockout duration (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sensor` in N_SENSORS: level motion inputs, already synchronised.
- `code` in CODE_W: keypad value, sampled only when `code_valid`=1.
- `code_valid` in 1: one-cycle code strobe.
- `active` out 1: high in EXIT_WAIT, ARMED, ENTRY_WAIT, ALARM.
- `alarm` out 1: high only in ALARM.
- `pending` out 1: high in EXIT_WAIT or ENTRY_WAIT.
- `locked` out 1: lockout in progress.
- `zones` out N_SENSORS: sensors latched on the ARMED→ENTRY_WAIT transition.
- `state` out 3: encoded FSM state (debug).

## Operation
- States: DISARMED, EXIT_WAIT, ARMED, ENTRY_WAIT, ALARM.
- DISARMED: `ARM_CODE` → EXIT_WAIT. Timer loads `EXIT_DELAY-1`. `zones` clears.
- EXIT_WAIT: sensors ignored. `DISARM_CODE` → DISARMED. When timer reaches 0 → ARMED.
- ARMED: any `sensor` bit high → ENTRY_WAIT. `zones` takes `sensor`, timer loads `ENTRY_DELAY-1`. `DISARM_CODE` → DISARMED.
- ENTRY_WAIT: `DISARM_CODE` → DISARMED. When timer reaches 0 → ALARM. Further sensor activity ORs into `zones`.
- ALARM: latched until `DISARM_CODE`, then → DISARMED. `zones` is held until the next arm.
- Correct code: any code causing a transition clears the fail counter.
- `ARM_CODE` while already armed: no-op, not counted as a failure.
- Any other code: increments the fail counter.
- Lockout: when the fail counter reaches `MAX_FAILS`, `locked`=1 for `LOCKOUT_CYCLES` cycles and the counter clears. While locked, all `code_valid` strobes are ignored and not counted. FSM timers keep running.
- Lockout from ENTRY_WAIT: if it is entered there, the FSM also goes immediately → ALARM (tamper).
- Simultaneous events:
  - Disarm beats a sensor in ARMED.
  - Disarm beats timer expiry in ENTRY_WAIT and EXIT_WAIT.
  - Lockout start takes effect in the same cycle as the failing code.

## Timing
- All outputs are registered. A code strobe in cycle t is visible on the outputs at t+1.
- EXIT_WAIT and ENTRY_WAIT last exactly `EXIT_DELAY` / `ENTRY_DELAY` cycles, counted from the entering edge.
- Reset (`rst_n`=0 at an edge) is valid in any state, mid-delay or mid-lockout. Next cycle:
  - state DISARMED
  - `active`=`alarm`=`pending`=`locked`=0
  - `zones`=0
  - fail counter and timers 0
- Timer widths are `$clog2(max(delay)+1)`. Timers saturate at 0; no wrap.

## Structure
- `alarm_pkg` holds:
  - the state enum (3-bit encoding)
  - the counter-width helper function
  - default code constants
- Sub-module `alarm_delay_timer`, parametrised width:
  - inputs: load, load value
  - outputs: running, expire pulse
  - instantiated twice: FSM delay timer and lockout timer.

## Test plan
- Arm then wait: `code`=10000 strobe → `active`=1 and `pending`=1 next cycle. `pending`=0, state ARMED after 16 cycles. `alarm` stays 0.
- Intrusion then disarm: in ARMED, `sensor`=2'b10 → ENTRY_WAIT and `zones`=2'b10. Strobe 00100 at cycle 10 → DISARMED, `active`=0, `alarm` never asserted.
- Entry expiry: in ARMED, `sensor`=2'b01 with no code → `alarm`=1 exactly 16 cycles later. Strobe 00100 → `alarm`=0 and `active`=0 next cycle.
- Lockout:
  - In DISARMED, three strobes of 00111 → `locked`=1 after the third.
  - A 10000 strobe during lockout is ignored (state stays DISARMED).
  - `locked`=0 after 64 cycles; 10000 then arms normally.
- Tamper and priority:
  - In ENTRY_WAIT, three wrong codes → `alarm`=1 next cycle, `locked`=1.
  - Separately: `sensor` high and 00100 in the same ARMED cycle → DISARMED.
- Reset mid-operation: `rst_n`=0 for one edge during ALARM with lockout active → next cycle every output is 0, state DISARMED.
